ped_crossing_ctrl: RTL and testbench

Pedestrian crossing controller sitting directly downstream of the traffic-light sequencer. It consumes the one-hot vehicle `lights` vector, latches pedestrian button requests, and drives the walk / don't-walk lamps. It grants a timed walk phase, followed by a flashing clearance phase, only while vehicles see red. It aborts to don't-walk immediately if the vehicle lights leave red or become illegal.

---
 rtl/traffic_pkg.sv | 22 ++
 rtl/flash_gen.sv | 33 +++
 rtl/ped_crossing_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ped_crossing_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// traffic_pkg: encodings shared between the traffic-light sequencer and the
// pedestrian crossing controller.
//   RED / YELLOW / GREEN : one-hot vehicle lamp encodings
//   ped_state_e          : pedestrian controller state (IDLE / WALK / CLEAR)
//   is_onehot3()         : true when a lamp vector is one of the legal encodings
package traffic_pkg;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WALK  = 2'd1,
    CLEAR = 2'd2
  } ped_state_e;

  function automatic logic is_onehot3(input logic [2:0] v);
    return (v == RED) || (v == YELLOW) || (v == GREEN);
  endfunction

endpackage

// File: rtl/flash_gen.sv
// flash_gen: square-wave generator for the flashing DON'T WALK lamp.
//   clock : sole clock, rising edge
//   reset : synchronous, active-high
//   en    : run enable; while low the output is parked at 1
//   flash : starts at 1 on the first enabled cycle, toggles every FLASH_DIV
//           enabled cycles
module flash_gen #(
  parameter int FLASH_DIV = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic en,
  output logic flash
);

  localparam int DW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;

  logic [DW-1:0] div_cnt;

  // Parking at 1 while disabled is what makes the first enabled cycle read 1.
  always_ff @(posedge clock) begin
    if (reset || !en) begin
      flash   <= 1'b1;
      div_cnt <= '0;
    end else if (div_cnt == DW'(FLASH_DIV - 1)) begin
      flash   <= ~flash;
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// ped_crossing_ctrl: pedestrian crossing controller downstream of the vehicle
// light sequencer. Latches button requests and grants one timed WALK phase
// (optionally followed by a flashing CLEAR phase) per vehicle red phase.
// Leaving red, or illegal lamp codes, abort immediately to DON'T WALK.
//
// Optional feature macro: PED_CLEAR_FLASH_EN
//   defined   : WALK is followed by CLEAR with flashing dont_walk and countdown
//   undefined : WALK expiry returns straight to IDLE, countdown stays 0,
//               flash_gen is not instantiated
//
// Ports:
//   clock       in   sole clock, rising edge
//   reset       in   synchronous, active-high
//   lights[2:0] in   vehicle lamps, one-hot (red=100, yellow=010, green=001)
//   ped_button  in   request level, already synchronised
//   walk        out  WALK lamp
//   dont_walk   out  DON'T WALK lamp (steady in IDLE, flashing in CLEAR)
//   req_pending out  request latched, not yet served
//   countdown   out  remaining CLEAR cycles, 0 outside CLEAR
//   abort       out  one-cycle pulse when WALK/CLEAR is cut short
//   lights_err  out  registered "lights not one-hot"
//   state_dbg   out  current FSM state, for observation only
module ped_crossing_ctrl
  import traffic_pkg::*;
#(
  parameter int WALK_CYCLES  = 8,
  parameter int CLEAR_CYCLES = 6,
  parameter int FLASH_DIV    = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [2:0]       lights,
  input  logic             ped_button,
  output logic             walk,
  output logic             dont_walk,
  output logic             req_pending,
  output logic [CNT_W-1:0] countdown,
  output logic             abort,
  output logic             lights_err,
  output ped_state_e       state_dbg
);

  // Elaboration-time parameter sanity.
  if (WALK_CYCLES < 1 || CLEAR_CYCLES < 1 || FLASH_DIV < 1 ||
      (2 ** CNT_W) <= WALK_CYCLES || (2 ** CNT_W) <= CLEAR_CYCLES) begin : g_bad_params
    $error("ped_crossing_ctrl: illegal parameter combination");
  end

  ped_state_e       state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             red_used;
  logic             grant;
  logic             abort_nxt;
  logic             abort_q;
  logic             lights_err_q;
  logic             is_red;

  // Illegal codes (including 000) are never equal to RED, so they abort too.
  assign is_red = (lights == RED);

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // --------------------------------------------------------------- next state
  // Abort is tested before counter expiry so it wins when both happen.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    grant     = 1'b0;
    abort_nxt = 1'b0;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (is_red && req_pending && !red_used) begin
          grant     = 1'b1;
          state_nxt = WALK;
          cnt_nxt   = CNT_W'(WALK_CYCLES - 1);
        end
      end
      WALK: begin
        if (!is_red) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          abort_nxt = 1'b1;
        end else if (cnt == '0) begin
`ifdef PED_CLEAR_FLASH_EN
          state_nxt = CLEAR;
          cnt_nxt   = CNT_W'(CLEAR_CYCLES - 1);
`else
          state_nxt = IDLE;
          cnt_nxt   = '0;
`endif
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      CLEAR: begin
        if (!is_red) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          abort_nxt = 1'b1;
        end else if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // ------------------------------------------------------- side registers
  // A press on the grant edge re-arms the request for the next red phase.
  // red_used remembers a grant until the vehicles leave red.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_pending  <= 1'b0;
      red_used     <= 1'b0;
      abort_q      <= 1'b0;
      lights_err_q <= 1'b0;
    end else begin
      req_pending  <= ped_button | (req_pending & ~grant);
      red_used     <= is_red & (red_used | grant);
      abort_q      <= abort_nxt;
      lights_err_q <= ~is_onehot3(lights);
    end
  end

`ifdef PED_CLEAR_FLASH_EN
  logic flash;

  flash_gen #(
    .FLASH_DIV (FLASH_DIV)
  ) u_flash_gen (
    .clock (clock),
    .reset (reset),
    .en    (state == CLEAR),
    .flash (flash)
  );
`endif

  // ------------------------------------------------------------------ outputs
  // Decoded only from flops, so every lamp changes on the clock edge.
  always_comb begin
    walk      = 1'b0;
    dont_walk = 1'b1;
    countdown = '0;
    case (state)
      WALK: begin
        walk      = 1'b1;
        dont_walk = 1'b0;
      end
      CLEAR: begin
`ifdef PED_CLEAR_FLASH_EN
        dont_walk = flash;
        countdown = cnt;
`endif
      end
      default: ;
    endcase
  end

  assign abort      = abort_q;
  assign lights_err = lights_err_q;
  assign state_dbg  = state;

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Bench for ped_crossing_ctrl. Vectors of {inputs, expected outputs after the
// edge} are built up front, then applied one per clock; the expected word is
// queued as the inputs are driven and popped once the edge has happened.
module tb_ped_crossing_ctrl;
  import traffic_pkg::*;

  localparam int WC = 8;
  localparam int CC = 6;
  localparam int FD = 2;
  localparam int CW = 8;
`ifdef PED_CLEAR_FLASH_EN
  localparam int PHASE = WC + CC;
`else
  localparam int PHASE = WC;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    lights = GREEN;
  logic          ped_button = 1'b0;
  logic          walk, dont_walk, req_pending, abort, lights_err;
  logic [CW-1:0] countdown;
  ped_state_e    state_dbg;

  ped_crossing_ctrl #(
    .WALK_CYCLES  (WC),
    .CLEAR_CYCLES (CC),
    .FLASH_DIV    (FD),
    .CNT_W        (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .lights      (lights),
    .ped_button  (ped_button),
    .walk        (walk),
    .dont_walk   (dont_walk),
    .req_pending (req_pending),
    .countdown   (countdown),
    .abort       (abort),
    .lights_err  (lights_err),
    .state_dbg   (state_dbg)
  );

  // ---------------------------------------------------------- clock / reset
  always #5 clock = ~clock;

  // ------------------------------------------------------------- vectors
  typedef struct {
    logic          rst;
    logic [2:0]    l;
    logic          btn;
    logic          w;
    logic          dw;
    logic          rp;
    logic [CW-1:0] cd;
    logic          ab;
    logic          le;
  } vec_t;

  vec_t             vecs[$];
  logic [CW+4:0]    exp_q[$];
  int               n_cmp  = 0;
  int               n_fail = 0;

  task automatic add_vec(input logic rst, input logic [2:0] l, input logic btn,
                         input logic w, input logic dw, input logic rp,
                         input logic [CW-1:0] cd, input logic ab, input logic le);
    vec_t v;
    v.rst = rst; v.l = l; v.btn = btn;
    v.w = w; v.dw = dw; v.rp = rp; v.cd = cd; v.ab = ab; v.le = le;
    vecs.push_back(v);
  endtask

  task automatic add_idle(input logic rst, input logic [2:0] l, input logic btn,
                          input logic rp, input logic le);
    add_vec(rst, l, btn, 1'b0, 1'b1, rp, '0, 1'b0, le);
  endtask

  task automatic add_walk(input logic btn, input logic rp);
    add_vec(1'b0, RED, btn, 1'b1, 1'b0, rp, '0, 1'b0, 1'b0);
  endtask

  // i-th cycle of CLEAR: countdown CC-1-i, lamp on for FD cycles, off for FD.
  task automatic add_clear(input int i, input logic rp);
    add_vec(1'b0, RED, 1'b0, 1'b0, ((i / FD) % 2) == 0, rp,
            CW'(CC - 1 - i), 1'b0, 1'b0);
  endtask

  // Remainder of a served phase after the grant vector, red held throughout.
  task automatic add_phase_tail(input logic rp);
    for (int i = 1; i < WC; i++) add_walk(1'b0, rp);
`ifdef PED_CLEAR_FLASH_EN
    for (int i = 0; i < CC; i++) add_clear(i, rp);
`endif
  endtask

  task automatic build_vectors();
    // reset, then a request while green / yellow
    add_idle(1'b1, GREEN, 1'b0, 1'b0, 1'b0);
    add_idle(1'b1, GREEN, 1'b0, 1'b0, 1'b0);
    add_idle(1'b0, GREEN, 1'b1, 1'b1, 1'b0);
    add_idle(1'b0, GREEN, 1'b0, 1'b1, 1'b0);
    add_idle(1'b0, GREEN, 1'b0, 1'b1, 1'b0);
    add_idle(1'b0, YELLOW, 1'b0, 1'b1, 1'b0);
    add_idle(1'b0, YELLOW, 1'b0, 1'b1, 1'b0);
    // red held 20 cycles: one full phase, then no second grant
    add_walk(1'b0, 1'b0);
    add_phase_tail(1'b0);
    for (int i = PHASE; i < 20; i++) add_idle(1'b0, RED, 1'b0, 1'b0, 1'b0);
    // abort three cycles into WALK
    add_idle(1'b0, GREEN, 1'b1, 1'b1, 1'b0);
    add_idle(1'b0, GREEN, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) add_walk(1'b0, 1'b0);
    add_vec(1'b0, GREEN, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b0);
    add_idle(1'b0, GREEN, 1'b0, 1'b0, 1'b0);
    // illegal codes while idle
    add_idle(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    add_idle(1'b0, 3'b111, 1'b0, 1'b0, 1'b1);
    add_idle(1'b0, GREEN, 1'b0, 1'b0, 1'b0);
    // illegal code for 2 cycles mid-phase
    add_idle(1'b0, GREEN, 1'b1, 1'b1, 1'b0);
    add_walk(1'b0, 1'b0);
`ifdef PED_CLEAR_FLASH_EN
    for (int i = 1; i < WC; i++) add_walk(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add_clear(i, 1'b0);
`else
    for (int i = 0; i < 2; i++) add_walk(1'b0, 1'b0);
`endif
    add_vec(1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b1, 1'b1);
    add_vec(1'b0, 3'b110, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b1);
    add_idle(1'b0, GREEN, 1'b0, 1'b0, 1'b0);
    // button held on the grant edge keeps the request for the next red
    add_idle(1'b0, GREEN, 1'b1, 1'b1, 1'b0);
    add_vec(1'b0, RED, 1'b1, 1'b1, 1'b0, 1'b1, '0, 1'b0, 1'b0);
    add_phase_tail(1'b1);
    add_idle(1'b0, RED, 1'b0, 1'b1, 1'b0);
    add_idle(1'b0, RED, 1'b0, 1'b1, 1'b0);
    add_idle(1'b0, GREEN, 1'b0, 1'b1, 1'b0);
    add_idle(1'b0, GREEN, 1'b0, 1'b1, 1'b0);
    add_walk(1'b0, 1'b0);
    // new press mid-walk, then reset: request is lost, no grant afterwards
    add_walk(1'b1, 1'b1);
    add_idle(1'b1, RED, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add_idle(1'b0, RED, 1'b0, 1'b0, 1'b0);
  endtask

  // ------------------------------------------------------------- scoreboard
  task automatic chk(input string name, input int idx,
                     input logic [CW-1:0] act, input logic [CW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s vec %0d: got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  initial begin
    logic [CW+4:0] e;
    build_vectors();
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clock);
      reset      = vecs[i].rst;
      lights     = vecs[i].l;
      ped_button = vecs[i].btn;
      exp_q.push_back({vecs[i].w, vecs[i].dw, vecs[i].rp, vecs[i].cd,
                       vecs[i].ab, vecs[i].le});
      @(posedge clock);
      #1;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard vec %0d: queue empty, expected one entry", i);
      end else begin
        n_cmp--;
        e = exp_q.pop_front();
        chk("walk",        i, CW'(walk),        CW'(e[CW+4]));
        chk("dont_walk",   i, CW'(dont_walk),   CW'(e[CW+3]));
        chk("req_pending", i, CW'(req_pending), CW'(e[CW+2]));
        chk("countdown",   i, countdown,        e[CW+1:2]);
        chk("abort",       i, CW'(abort),       CW'(e[1]));
        chk("lights_err",  i, CW'(lights_err),  CW'(e[0]));
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
